// File: rtl/id_regfile_fwd_if.sv
// Operand/forwarding bundle between the ID-stage pipeline logic (master)
// and the register file with bypass network (slave).
interface id_regfile_fwd_if #(
    parameter int DW = 32
);
    logic [DW+5:0] wb_to_rf_bus;   // {we, waddr[4:0], wdata}
    logic [DW+6:0] ex_fwd_bus;     // {is_load, we, waddr[4:0], wdata}
    logic [DW+5:0] mem_fwd_bus;    // {we, waddr[4:0], wdata}
    logic [4:0]    raddr1;
    logic [4:0]    raddr2;
    logic          rs_used;
    logic          rt_used;
    logic [5:0]    stall;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          stallreq_id;

    modport master (
        output wb_to_rf_bus,
        output ex_fwd_bus,
        output mem_fwd_bus,
        output raddr1,
        output raddr2,
        output rs_used,
        output rt_used,
        output stall,
        input  rdata1,
        input  rdata2,
        input  stallreq_id
    );

    modport slave (
        input  wb_to_rf_bus,
        input  ex_fwd_bus,
        input  mem_fwd_bus,
        input  raddr1,
        input  raddr2,
        input  rs_used,
        input  rt_used,
        input  stall,
        output rdata1,
        output rdata2,
        output stallreq_id
    );
endinterface

// File: rtl/id_regfile_fwd.sv
// ID-stage GPR file with EX/MEM/WB operand bypass and load-use stall request.
// r0 reads as zero and ignores writes. Writes commit on the clock edge and are
// never held off by the pipeline stall bus.
//
// Build option RF_WB_BYPASS_EN:
//   defined   - a WB write in flight is forwarded to same-cycle ID reads.
//   undefined - reads see the pre-edge array value; an operand whose youngest
//               producer is WB raises a one-cycle stall request instead.
//
// Load-use control state:
//   state   | meaning
//   LU_IDLE | no bubble pending, stallreq_id follows the hazard
//   LU_WAIT | bubble just requested, producer has moved on, request masked
module id_regfile_fwd #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    id_regfile_fwd_if.slave bus
);
    localparam int AW = 5;

    typedef enum logic {
        LU_IDLE = 1'b0,
        LU_WAIT = 1'b1
    } lu_state_e;

    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          ex_is_load;
    logic          ex_we;
    logic [AW-1:0] ex_waddr;
    logic [DW-1:0] ex_wdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic [DW-1:0] regs [NREG];

    logic [AW-1:0] rd_addr [2];
    logic [1:0]    rd_used;
    logic [DW-1:0] rd_val  [2];
    logic [1:0]    ex_hit;
    logic [1:0]    mem_hit;
    logic [1:0]    wb_hit;
    logic [1:0]    lu_hit;
    logic [1:0]    wb_late;
    logic          hazard;

    lu_state_e     lu_wait;

    // Only the ID bit of the stall bus matters here.
    logic          unused_stall_bits;
    assign unused_stall_bits = ^{bus.stall[5:3], bus.stall[1:0]};

    assign {wb_we, wb_waddr, wb_wdata}                = bus.wb_to_rf_bus;
    assign {ex_is_load, ex_we, ex_waddr, ex_wdata}    = bus.ex_fwd_bus;
    assign {mem_we, mem_waddr, mem_wdata}             = bus.mem_fwd_bus;

    assign rd_addr[0] = bus.raddr1;
    assign rd_addr[1] = bus.raddr2;
    assign rd_used    = {bus.rt_used, bus.rs_used};

    // Commit WB results into the array; r0 stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_waddr != '0)) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    // Match each read port against every in-flight producer.
    always_comb begin
        ex_hit  = '0;
        mem_hit = '0;
        wb_hit  = '0;
        for (int p = 0; p < 2; p++) begin
            ex_hit[p]  = ex_we  && (ex_waddr  == rd_addr[p]);
            mem_hit[p] = mem_we && (mem_waddr == rd_addr[p]);
            wb_hit[p]  = wb_we  && (wb_waddr  == rd_addr[p]);
        end
    end

    // Priority select per port: zero, EX, MEM, (WB), array.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = regs[rd_addr[p]];
            if (rd_addr[p] == '0) begin
                rd_val[p] = '0;
            end else if (ex_hit[p]) begin
                rd_val[p] = ex_wdata;
            end else if (mem_hit[p]) begin
                rd_val[p] = mem_wdata;
`ifdef RF_WB_BYPASS_EN
            end else if (wb_hit[p]) begin
                rd_val[p] = wb_wdata;
`endif
            end
        end
    end

    // Operands that cannot be delivered correctly this cycle.
    always_comb begin
        lu_hit  = '0;
        wb_late = '0;
        for (int p = 0; p < 2; p++) begin
            lu_hit[p] = rd_used[p] && (rd_addr[p] != '0) && ex_is_load && ex_hit[p];
`ifndef RF_WB_BYPASS_EN
            wb_late[p] = rd_used[p] && (rd_addr[p] != '0) && wb_hit[p]
                         && !ex_hit[p] && !mem_hit[p];
`endif
        end
        hazard = (|lu_hit) || (|wb_late);
    end

    // One bubble per hazard: once requested, mask the request for a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_wait <= LU_IDLE;
        end else begin
            case (lu_wait)
                LU_IDLE: if (hazard && !bus.stall[2]) lu_wait <= LU_WAIT;
                LU_WAIT: lu_wait <= LU_IDLE;
                default: lu_wait <= LU_IDLE;
            endcase
        end
    end

    // Outputs are quiet while reset is held.
    always_comb begin
        bus.rdata1      = rst ? '0 : rd_val[0];
        bus.rdata2      = rst ? '0 : rd_val[1];
        bus.stallreq_id = !rst && (lu_wait == LU_IDLE) && hazard;
    end
endmodule
